// File: rtl/am29xx_pkg.sv
// Shared definitions for the am29xx sequencer family: source selects,
// stack operation encoding, stack occupancy states and a decode helper.
package am29xx_pkg;

    localparam logic [1:0] SEL_UPC = 2'b00;
    localparam logic [1:0] SEL_AR  = 2'b01;
    localparam logic [1:0] SEL_STK = 2'b10;
    localparam logic [1:0] SEL_DIN = 2'b11;

    typedef enum logic [1:0] {
        STK_NOP  = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10
    } stk_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_PART  = 2'b01,
        ST_FULL  = 2'b10
    } stk_state_e;

    // fe_ gates the stack; pup chooses push (1) or pop (0)
    function automatic stk_op_e decode_stk_op(input logic fe_n, input logic pup);
        if (fe_n)
            return STK_NOP;
        return pup ? STK_PUSH : STK_POP;
    endfunction

endpackage

// File: rtl/am2911x_if.sv
// Control/status bundle of the am2911x sequencer slice. The tri-state y
// bus stays a plain port on the top so it can be shared on a board-level net.
interface am2911x_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic [1:0]       s;
    logic             zero_;
    logic             oe_;
    logic             cn;
    logic             re_;
    logic             fe_;
    logic             pup;
    logic             cld_;
    logic             cdec;
    logic             cn4;
    logic             full;
    logic             empty;
    logic             serr;
    logic             cntz;

    modport master (
        output din, s, zero_, oe_, cn, re_, fe_, pup, cld_, cdec,
        input  cn4, full, empty, serr, cntz
    );

    modport slave (
        input  din, s, zero_, oe_, cn, re_, fe_, pup, cld_, cdec,
        output cn4, full, empty, serr, cntz
    );
endinterface

// File: rtl/am2911x_stack.sv
// DEPTH x WIDTH LIFO for the sequencer: occupancy-tracking state machine,
// full/empty decode and a sticky over/underflow flag.
module am2911x_stack
    import am29xx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             cp,
    input  logic             clr_,
    input  stk_op_e          op,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic             serr
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int OCCW = PTRW + 1;

    stk_state_e       state_q, state_d;
    logic [OCCW-1:0]  occ_q, occ_d;
    logic             serr_q, serr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  top_idx;
    logic [PTRW-1:0]  wr_idx;
    logic             do_push;

    assign top_idx = occ_q[PTRW-1:0] - PTRW'(1);
    assign wr_idx  = occ_q[PTRW-1:0];
    assign do_push = (op == STK_PUSH) && (state_q != ST_FULL);

    // Next occupancy/state; illegal operations leave the stack alone and flag serr
    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        serr_d  = serr_q;
        case (op)
            STK_PUSH: begin
                if (state_q == ST_FULL) begin
                    serr_d = 1'b1;
                end else begin
                    occ_d   = occ_q + OCCW'(1);
                    state_d = (occ_d == OCCW'(DEPTH)) ? ST_FULL : ST_PART;
                end
            end
            STK_POP: begin
                if (state_q == ST_EMPTY) begin
                    serr_d = 1'b1;
                end else begin
                    occ_d   = occ_q - OCCW'(1);
                    state_d = (occ_q == OCCW'(1)) ? ST_EMPTY : ST_PART;
                end
            end
            default: ;
        endcase
    end

    // Occupancy state machine and sticky error, cleared only by clr_
    always_ff @(posedge cp or negedge clr_) begin
        if (!clr_) begin
            state_q <= ST_EMPTY;
            occ_q   <= '0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            serr_q  <= serr_d;
        end
    end

    // Storage array; contents are meaningless while empty so it has no reset
    always_ff @(posedge cp) begin
        if (do_push)
            mem_q[wr_idx] <= wdata;
    end

    assign top   = (state_q == ST_EMPTY) ? '0 : mem_q[top_idx];
    assign full  = (state_q == ST_FULL);
    assign empty = (state_q == ST_EMPTY);
    assign serr  = serr_q;

endmodule

// File: rtl/am2911x.sv
// am2911x microprogram sequencer slice: source mux, zero forcing, incrementer
// with cascade carry, microprogram counter, address register, loop counter
// and the return-address stack.
module am2911x
    import am29xx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             cp,
    input  logic             clr_,
    am2911x_if.slave         bus,
    output wire [WIDTH-1:0]  y
);
    logic [WIDTH-1:0] upc_q, upc_d;
    logic [WIDTH-1:0] ar_q, ar_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] incin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] stk_top;
    stk_op_e          stk_op;

    assign stk_op = decode_stk_op(bus.fe_, bus.pup);

    // Address path: select source, force zero, increment with carry-in
    always_comb begin
        x = upc_q;
        case (bus.s)
            SEL_UPC: x = upc_q;
            SEL_AR:  x = ar_q;
            SEL_STK: x = stk_top;
            SEL_DIN: x = bus.din;
            default: x = upc_q;
        endcase
        incin = bus.zero_ ? x : '0;
        sum   = {1'b0, incin} + {{WIDTH{1'b0}}, bus.cn};
        upc_d = sum[WIDTH-1:0];
    end

    // Register loads: AR from din, loop counter loads or saturating decrement
    always_comb begin
        ar_d  = bus.re_ ? ar_q : bus.din;
        cnt_d = cnt_q;
        if (!bus.cld_)
            cnt_d = bus.din;
        else if (bus.cdec && (cnt_q != '0))
            cnt_d = cnt_q - WIDTH'(1);
    end

    // Architectural registers of the slice
    always_ff @(posedge cp or negedge clr_) begin
        if (!clr_) begin
            upc_q <= '0;
            ar_q  <= '0;
            cnt_q <= '0;
        end else begin
            upc_q <= upc_d;
            ar_q  <= ar_d;
            cnt_q <= cnt_d;
        end
    end

    // Push saves the current (pre-increment) microprogram counter
    am2911x_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .cp    (cp),
        .clr_  (clr_),
        .op    (stk_op),
        .wdata (upc_q),
        .top   (stk_top),
        .full  (bus.full),
        .empty (bus.empty),
        .serr  (bus.serr)
    );

    assign y        = bus.oe_ ? {WIDTH{1'bz}} : incin;
    assign bus.cn4  = sum[WIDTH];
    assign bus.cntz = (cnt_q == '0);

endmodule

// File: tb/tb_am2911x.sv
// Directed self-checking bench for am2911x with hand-computed expectations.
module tb_am2911x;
    import am29xx_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       cp;
    logic       clr_;
    logic       tb_drive;
    wire  [7:0] y;
    int         checks;
    int         failures;

    am2911x_if #(.WIDTH(WIDTH)) bus ();

    // Weak helper driver: shows the value seen on y when the DUT releases the bus
    assign y = tb_drive ? 8'h3C : 8'hzz;

    am2911x #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .cp   (cp),
        .clr_ (clr_),
        .bus  (bus),
        .y    (y)
    );

    // Free-running clock, 10 ns period
    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    // Advance one rising edge and settle before sampling
    task automatic applyStimulus();
        @(posedge cp);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Linear directed sequence
    initial begin
        checks    = 0;
        failures  = 0;
        tb_drive  = 1'b0;
        clr_      = 1'b0;
        bus.din   = 8'h00;
        bus.s     = SEL_UPC;
        bus.zero_ = 1'b1;
        bus.oe_   = 1'b0;
        bus.cn    = 1'b1;
        bus.re_   = 1'b1;
        bus.fe_   = 1'b1;
        bus.pup   = 1'b0;
        bus.cld_  = 1'b1;
        bus.cdec  = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_y",     32'(y),         32'h00);
        checkOutput("rst_empty", 32'(bus.empty), 32'h1);
        checkOutput("rst_full",  32'(bus.full),  32'h0);
        checkOutput("rst_cntz",  32'(bus.cntz),  32'h1);
        checkOutput("rst_serr",  32'(bus.serr),  32'h0);
        @(negedge cp);
        clr_ = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("upc_after3", 32'(y),       32'h03);
        checkOutput("cn4_low",    32'(bus.cn4), 32'h0);

        // Carry out and wrap
        @(negedge cp);
        bus.s   = SEL_DIN;
        bus.din = 8'hFF;
        #1;
        checkOutput("carry_y",   32'(y),       32'hFF);
        checkOutput("carry_cn4", 32'(bus.cn4), 32'h1);
        applyStimulus();
        bus.s = SEL_UPC;
        #1;
        checkOutput("wrap_y", 32'(y), 32'h00);

        // Load uPC to 0x10, then fill the stack
        @(negedge cp);
        bus.s   = SEL_DIN;
        bus.din = 8'h0F;
        applyStimulus();
        bus.s   = SEL_UPC;
        #1;
        checkOutput("upc_10", 32'(y), 32'h10);
        bus.fe_ = 1'b0;
        bus.pup = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("push_full",  32'(bus.full),  32'h1);
        checkOutput("push_empty", 32'(bus.empty), 32'h0);
        checkOutput("push_serr",  32'(bus.serr),  32'h0);
        applyStimulus();
        checkOutput("ovf_serr", 32'(bus.serr), 32'h1);
        checkOutput("ovf_full", 32'(bus.full), 32'h1);

        // Pop sequence reading the top through the mux
        bus.pup = 1'b0;
        bus.s   = SEL_STK;
        #1;
        checkOutput("pop0", 32'(y), 32'h13);
        applyStimulus();
        checkOutput("pop1", 32'(y), 32'h12);
        applyStimulus();
        checkOutput("pop2", 32'(y), 32'h11);
        applyStimulus();
        checkOutput("pop3", 32'(y), 32'h10);
        applyStimulus();
        checkOutput("pop_empty", 32'(bus.empty), 32'h1);
        bus.fe_ = 1'b1;

        // Asynchronous clear mid-cycle, then underflow
        @(negedge cp);
        #2 clr_ = 1'b0;
        #1;
        checkOutput("aclr_serr", 32'(bus.serr), 32'h0);
        @(negedge cp);
        clr_    = 1'b1;
        bus.fe_ = 1'b0;
        bus.pup = 1'b0;
        bus.s   = SEL_STK;
        #1;
        checkOutput("unf_y_pre", 32'(y), 32'h00);
        applyStimulus();
        checkOutput("unf_serr",  32'(bus.serr),  32'h1);
        checkOutput("unf_empty", 32'(bus.empty), 32'h1);
        checkOutput("unf_y",     32'(y),         32'h00);
        bus.fe_ = 1'b1;
        bus.s   = SEL_UPC;

        // Loop counter: load 3, decrement to zero and saturate
        bus.cld_ = 1'b0;
        bus.cdec = 1'b1;
        bus.din  = 8'h03;
        applyStimulus();
        bus.cld_ = 1'b1;
        checkOutput("cnt_load", 32'(bus.cntz), 32'h0);
        applyStimulus();
        checkOutput("cnt_dec1", 32'(bus.cntz), 32'h0);
        applyStimulus();
        checkOutput("cnt_dec2", 32'(bus.cntz), 32'h0);
        applyStimulus();
        checkOutput("cnt_dec3", 32'(bus.cntz), 32'h1);
        applyStimulus();
        checkOutput("cnt_sat",  32'(bus.cntz), 32'h1);
        bus.cld_ = 1'b0;
        bus.din  = 8'h01;
        applyStimulus();
        checkOutput("cnt_ld_wins", 32'(bus.cntz), 32'h0);
        bus.cld_ = 1'b1;
        bus.cdec = 1'b0;

        // AR load, same-cycle old-AR output, zero_ and oe_
        bus.re_ = 1'b0;
        bus.din = 8'h5A;
        applyStimulus();
        bus.re_ = 1'b1;
        bus.s   = SEL_AR;
        #1;
        checkOutput("ar_y", 32'(y), 32'h5A);
        bus.zero_ = 1'b0;
        #1;
        checkOutput("zero_y",   32'(y),       32'h00);
        checkOutput("zero_cn4", 32'(bus.cn4), 32'h0);
        bus.zero_ = 1'b1;
        bus.re_   = 1'b0;
        bus.din   = 8'h77;
        #1;
        checkOutput("ar_old", 32'(y), 32'h5A);
        applyStimulus();
        bus.re_ = 1'b1;
        checkOutput("ar_new", 32'(y), 32'h77);
        bus.oe_  = 1'b1;
        tb_drive = 1'b1;
        #1;
        checkOutput("oe_hiz", 32'(y), 32'h3C);
        tb_drive = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #20000;
        failures++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
